// File: rtl/td4_pkg.sv
// Shared widths, instruction field slices and opcode constants for the 4-bit CPU.
package td4_pkg;

    localparam int unsigned PC_W    = 4;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned IMM_W   = 4;
    localparam int unsigned INSTR_W = 8;

    localparam logic [PC_W-1:0] RESET_PC = '0;

    localparam int unsigned OP_MSB  = 7;
    localparam int unsigned OP_LSB  = 4;
    localparam int unsigned IMM_MSB = 3;
    localparam int unsigned IMM_LSB = 0;

    // Opcodes, shared with the decoder
    localparam logic [OP_W-1:0] OPC_ADD_A  = 4'b0000;
    localparam logic [OP_W-1:0] OPC_MOV_AB = 4'b0001;
    localparam logic [OP_W-1:0] OPC_IN_A   = 4'b0010;
    localparam logic [OP_W-1:0] OPC_MOV_A  = 4'b0011;
    localparam logic [OP_W-1:0] OPC_MOV_BA = 4'b0100;
    localparam logic [OP_W-1:0] OPC_ADD_B  = 4'b0101;
    localparam logic [OP_W-1:0] OPC_IN_B   = 4'b0110;
    localparam logic [OP_W-1:0] OPC_MOV_B  = 4'b0111;
    localparam logic [OP_W-1:0] OPC_OUT_B  = 4'b1001;
    localparam logic [OP_W-1:0] OPC_OUT_IM = 4'b1011;
    localparam logic [OP_W-1:0] OPC_JNC    = 4'b1110;
    localparam logic [OP_W-1:0] OPC_JMP    = 4'b1111;

endpackage

// File: rtl/td4_pc.sv
// Program counter: sync reset, enable, jump load, increment with natural wrap.
module td4_pc
    import td4_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            load,
    input  logic [PC_W-1:0] load_addr,
    output logic [PC_W-1:0] pc
);

    // Reset wins; otherwise advance or redirect only on enabled edges
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (en) begin
            if (load) begin
                pc <= load_addr;
            end else begin
                pc <= pc + PC_W'(1);
            end
        end
    end

endmodule

// File: rtl/td4_fetch.sv
// Fetch stage: PC, synchronous ROM interface, F1 tag, instruction register, jump squash.
module td4_fetch
    import td4_pkg::*;
(
    input  logic               in_clk,
    input  logic               in_rst,
    input  logic               in_en,
    output logic               out_rom_en,
    output logic [PC_W-1:0]    out_rom_addr,
    input  logic [INSTR_W-1:0] in_rom_data,
    input  logic               in_jump,
    input  logic [PC_W-1:0]    in_jump_addr,
    output logic [OP_W-1:0]    out_op,
    output logic [IMM_W-1:0]   out_imm,
    output logic [PC_W-1:0]    out_pc,
    output logic               out_valid
);

    logic [PC_W-1:0] pc_q;
    logic            f1_valid;
    logic [PC_W-1:0] f1_pc;
    logic            jump_take;

    // A jump only counts when it comes from a real instruction on a running edge
    assign jump_take = in_en & in_jump & out_valid;

    // ROM follows the PC directly; a stalled ROM keeps its output word
    assign out_rom_en   = in_en;
    assign out_rom_addr = pc_q;

    td4_pc u_pc (
        .clk       (in_clk),
        .rst       (in_rst),
        .en        (in_en),
        .load      (jump_take),
        .load_addr (in_jump_addr),
        .pc        (pc_q)
    );

    // F1 tag and instruction register; a taken jump kills both in-flight slots
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            f1_valid  <= 1'b0;
            f1_pc     <= '0;
            out_op    <= '0;
            out_imm   <= '0;
            out_pc    <= '0;
            out_valid <= 1'b0;
        end else if (in_en) begin
            f1_valid  <= ~jump_take;
            f1_pc     <= pc_q;
            out_op    <= in_rom_data[OP_MSB:OP_LSB];
            out_imm   <= in_rom_data[IMM_MSB:IMM_LSB];
            out_pc    <= f1_pc;
            out_valid <= f1_valid & ~jump_take;
        end
    end

endmodule

// File: tb/tb_td4_fetch.sv
// Directed bench for td4_fetch with a 16x8 synchronous ROM model, ROM[i] = {i, ~i}.
module tb_td4_fetch;

    logic       in_clk = 1'b0;
    logic       in_rst;
    logic       in_en;
    logic       out_rom_en;
    logic [3:0] out_rom_addr;
    logic [7:0] in_rom_data = 8'h00;
    logic       in_jump;
    logic [3:0] in_jump_addr;
    logic [3:0] out_op;
    logic [3:0] out_imm;
    logic [3:0] out_pc;
    logic       out_valid;

    logic [7:0] rom [16];
    int checks = 0;
    int errors = 0;

    always #5 in_clk = ~in_clk;

    // Synchronous ROM with read enable
    always @(posedge in_clk) begin
        if (out_rom_en) in_rom_data <= rom[out_rom_addr];
    end

    td4_fetch dut (
        .in_clk       (in_clk),
        .in_rst       (in_rst),
        .in_en        (in_en),
        .out_rom_en   (out_rom_en),
        .out_rom_addr (out_rom_addr),
        .in_rom_data  (in_rom_data),
        .in_jump      (in_jump),
        .in_jump_addr (in_jump_addr),
        .out_op       (out_op),
        .out_imm      (out_imm),
        .out_pc       (out_pc),
        .out_valid    (out_valid)
    );

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full view of a valid instruction at address a: op=a, imm=~a
    task automatic check_instr(input string tag, input logic [3:0] a);
        logic [3:0] inv;
        inv = ~a;
        check({tag, " valid"}, 32'(out_valid), 32'(1));
        check({tag, " pc"},    32'(out_pc),    32'(a));
        check({tag, " op"},    32'(out_op),    32'(a));
        check({tag, " imm"},   32'(out_imm),   32'(inv));
    endtask

    initial begin
        logic [3:0] e;
        for (int i = 0; i < 16; i++) begin
            rom[i] = {4'(i), ~4'(i)};
        end
        in_rst = 1'b1; in_en = 1'b1; in_jump = 1'b0; in_jump_addr = 4'h0;

        // Reset held two cycles
        step(); step();
        check("rst valid", 32'(out_valid), 32'(0));
        check("rst addr",  32'(out_rom_addr), 32'(0));
        check("rst op",    32'(out_op), 32'(0));
        check("rst imm",   32'(out_imm), 32'(0));
        check("rst rom_en", 32'(out_rom_en), 32'(1));

        // Fetch start: first valid instruction on the 2nd enabled edge
        in_rst = 1'b0;
        step();
        check("fetch e1 valid", 32'(out_valid), 32'(0));
        check("fetch e1 addr",  32'(out_rom_addr), 32'(1));
        step();
        check_instr("fetch e2", 4'h0);
        step();
        check_instr("fetch e3", 4'h1);
        check("fetch e3 addr", 32'(out_rom_addr), 32'(3));

        // Wrap: 17 enabled cycles, out_pc runs 2..F,0,1,2
        for (int k = 0; k < 17; k++) begin
            step();
            e = 4'(k + 2);
            check_instr("wrap", e);
            check("wrap addr", 32'(out_rom_addr), 32'(4'(e + 4'd2)));
        end

        // Advance to out_pc=5
        step(); step(); step();
        check_instr("pre-jump", 4'h5);

        // Jump to 2: two bubbles, then target
        in_jump = 1'b1; in_jump_addr = 4'h2;
        step();
        in_jump = 1'b0;
        check("jump b1 valid", 32'(out_valid), 32'(0));
        check("jump b1 addr",  32'(out_rom_addr), 32'(2));
        step();
        check("jump b2 valid", 32'(out_valid), 32'(0));
        step();
        check_instr("jump target", 4'h2);

        // Advance to out_pc=7
        step(); step(); step(); step(); step();
        check_instr("pre-stall", 4'h7);

        // Stall three cycles with a jump presented; everything holds
        in_en = 1'b0; in_jump = 1'b1; in_jump_addr = 4'hC;
        for (int k = 0; k < 3; k++) begin
            step();
            check_instr("stall", 4'h7);
            check("stall addr",   32'(out_rom_addr), 32'(9));
            check("stall rom_en", 32'(out_rom_en), 32'(0));
        end
        in_en = 1'b1; in_jump = 1'b0;
        step();
        check_instr("resume", 4'h8);
        step();
        check_instr("pre-rst", 4'h9);

        // Reset mid-run
        in_rst = 1'b1;
        step();
        check("midrst valid", 32'(out_valid), 32'(0));
        check("midrst addr",  32'(out_rom_addr), 32'(0));
        check("midrst pc",    32'(out_pc), 32'(0));
        check("midrst op",    32'(out_op), 32'(0));
        in_rst = 1'b0;

        // Jump while out_valid=0 must be ignored
        in_jump = 1'b1; in_jump_addr = 4'h9;
        step();
        in_jump = 1'b0;
        check("restart e1 valid", 32'(out_valid), 32'(0));
        check("restart e1 addr",  32'(out_rom_addr), 32'(1));
        step();
        check_instr("restart e2", 4'h0);
        step();
        check_instr("restart e3", 4'h1);

        // Jump to F, then wrap to 0
        in_jump = 1'b1; in_jump_addr = 4'hF;
        step();
        in_jump = 1'b0;
        check("jmpF b1 valid", 32'(out_valid), 32'(0));
        step();
        check("jmpF b2 valid", 32'(out_valid), 32'(0));
        step();
        check_instr("jmpF target", 4'hF);
        step();
        check_instr("jmpF wrap", 4'h0);

        // Self-loop jump to 0 from out_pc=0
        in_jump = 1'b1; in_jump_addr = 4'h0;
        step();
        in_jump = 1'b0;
        check("self b1 valid", 32'(out_valid), 32'(0));
        step();
        check("self b2 valid", 32'(out_valid), 32'(0));
        step();
        check_instr("self target", 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
